// File: rtl/fpu_ftoi.sv
// fpu_ftoi: IEEE-754 single to int32 conversion, round-to-nearest-even.
// A magnitude register is shifted one bit per cycle toward the integer
// point, then rounded and signed in a single ROUND cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an operand, in_ready=1
// SHIFT | magnitude moves 1 bit per cycle, k_q cycles remaining
// ROUND | apply RNE increment, negate, clamp on overflow
// DONE  | result presented, held until out_ready
module fpu_ftoi (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y,
   output logic        ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        sign_q, sign_d;
   logic        ovf_q, ovf_d;
   logic        left_q, left_d;
   logic        guard_q, guard_d;
   logic        sticky_q, sticky_d;
   logic [4:0]  k_q, k_d;
   logic [31:0] mag_q, mag_d;
   logic [31:0] y_q, y_d;

   logic [7:0]  exp_w;
   logic [22:0] man_w;
   logic        acc_sign;
   logic        acc_ovf;
   logic        acc_left;
   logic [4:0]  acc_k;
   logic [31:0] acc_mag;
   logic [7:0]  diff_w;
   logic        rnd_inc;
   logic [31:0] mag_rnd;

   assign exp_w = x[30:23];
   assign man_w = x[22:0];

   // Classify the incoming operand: overflow, initial magnitude, shift direction and count.
   always_comb begin
      acc_sign = x[31];
      acc_ovf  = 1'b0;
      acc_left = 1'b0;
      acc_k    = 5'd0;
      acc_mag  = {8'd0, 1'b1, man_w};
      diff_w   = 8'd0;
      if (exp_w == 8'd0) begin
         acc_mag = 32'd0;
      end else if (exp_w == 8'd255) begin
         acc_ovf  = 1'b1;
         // NaN saturates positive regardless of its sign bit
         acc_sign = x[31] & (man_w == 23'd0);
      end else if (exp_w >= 8'd158) begin
         if (x == 32'hCF00_0000) begin
            // exactly -2^31 is representable
            acc_mag = 32'h8000_0000;
         end else begin
            acc_ovf = 1'b1;
         end
      end else if (exp_w >= 8'd150) begin
         acc_left = 1'b1;
         diff_w   = exp_w - 8'd150;
         acc_k    = diff_w[4:0];
      end else if (exp_w < 8'd125) begin
         // 25 shifts already push every mantissa bit past guard
         acc_k = 5'd25;
      end else begin
         diff_w = 8'd150 - exp_w;
         acc_k  = diff_w[4:0];
      end
   end

   assign rnd_inc = guard_q & (sticky_q | mag_q[0]);
   assign mag_rnd = mag_q + {31'd0, rnd_inc};

   // Next-state and datapath updates for the conversion sequence.
   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      ovf_d    = ovf_q;
      left_d   = left_q;
      guard_d  = guard_q;
      sticky_d = sticky_q;
      k_d      = k_q;
      mag_d    = mag_q;
      y_d      = y_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d   = acc_sign;
               ovf_d    = acc_ovf;
               left_d   = acc_left;
               k_d      = acc_k;
               mag_d    = acc_mag;
               guard_d  = 1'b0;
               sticky_d = 1'b0;
               state_d  = (acc_k != 5'd0) ? SHIFT : ROUND;
            end
         end
         SHIFT: begin
            if (left_q) begin
               mag_d = {mag_q[30:0], 1'b0};
            end else begin
               mag_d    = {1'b0, mag_q[31:1]};
               guard_d  = mag_q[0];
               sticky_d = sticky_q | guard_q;
            end
            k_d = k_q - 5'd1;
            if (k_q == 5'd1) begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            if (ovf_q) begin
               y_d = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else if (sign_q) begin
               y_d = 32'd0 - mag_rnd;
            end else begin
               y_d = mag_rnd;
            end
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         ovf_q    <= 1'b0;
         left_q   <= 1'b0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         k_q      <= 5'd0;
         mag_q    <= 32'd0;
         y_q      <= 32'd0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         ovf_q    <= ovf_d;
         left_q   <= left_d;
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
         k_q      <= k_d;
         mag_q    <= mag_d;
         y_q      <= y_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign y         = y_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_fpu_ftoi.sv
// Directed bench for fpu_ftoi: conversions, rounding, range limits,
// output hold under backpressure and reset during a shift.
module tb_fpu_ftoi;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;
   logic        ovf;

   int n_cmp;
   int n_mis;

   fpu_ftoi dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // One operand with out_ready=1; lat counts the accepting edge as edge 1.
   task automatic run_op(input string tag, input logic [31:0] xv,
                         input logic [31:0] exp_y, input logic exp_ovf, input int lat);
      int n;
      @(negedge clk);
      x         = xv;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      n = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && n < 60) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk({tag, " latency"}, n, lat);
      chk({tag, " y"}, y, exp_y);
      chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
      @(posedge clk);
      @(negedge clk);
      chk({tag, " idle"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      int n;
      n_cmp     = 0;
      n_mis     = 0;
      rstn      = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x         = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst y", y, 32'd0);
      chk("rst ovf", {31'd0, ovf}, 32'd0);
      rstn = 1'b1;

      run_op("one",     32'h3F80_0000, 32'h0000_0001, 1'b0, 25);
      run_op("2.5",     32'h4020_0000, 32'h0000_0002, 1'b0, 24);
      run_op("3.5",     32'h4060_0000, 32'h0000_0004, 1'b0, 24);
      run_op("0.5",     32'h3F00_0000, 32'h0000_0000, 1'b0, 26);
      run_op("1.5",     32'h3FC0_0000, 32'h0000_0002, 1'b0, 25);
      run_op("-1.5",    32'hBFC0_0000, 32'hFFFF_FFFE, 1'b0, 25);
      run_op("-0.25",   32'hBE80_0000, 32'h0000_0000, 1'b0, 27);
      run_op("2^24+2",  32'h4B80_0001, 32'h0100_0002, 1'b0, 3);
      run_op("maxpos",  32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 9);
      run_op("2^31",    32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 2);
      run_op("-2^31",   32'hCF00_0000, 32'h8000_0000, 1'b0, 2);
      run_op("<-2^31",  32'hCF00_0001, 32'h8000_0000, 1'b1, 2);
      run_op("+inf",    32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 2);
      run_op("-nan",    32'hFFC0_0000, 32'h7FFF_FFFF, 1'b1, 2);
      run_op("zero",    32'h0000_0000, 32'h0000_0000, 1'b0, 2);
      run_op("denorm",  32'h8000_0001, 32'h0000_0000, 1'b0, 2);

      // backpressure: result held in DONE, a stray in_valid is ignored
      @(negedge clk);
      x         = 32'h4060_0000;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      n = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && n < 60) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("hs latency", n, 24);
      for (int i = 0; i < 5; i++) begin
         chk("hs y", y, 32'h0000_0004);
         chk("hs in_ready", {31'd0, in_ready}, 32'd0);
         chk("hs out_valid", {31'd0, out_valid}, 32'd1);
         in_valid = (i == 2);
         x        = (i == 2) ? 32'h3F80_0000 : 32'h4060_0000;
         @(posedge clk);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      chk("hs y after pulse", y, 32'h0000_0004);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("hs release in_ready", {31'd0, in_ready}, 32'd1);
      chk("hs release out_valid", {31'd0, out_valid}, 32'd0);

      // reset in the middle of a SHIFT sequence
      @(negedge clk);
      x        = 32'h3F80_0000;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("mid busy", {31'd0, in_ready}, 32'd0);
      rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid rst in_ready", {31'd0, in_ready}, 32'd1);
      chk("mid rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid rst y", y, 32'd0);
      chk("mid rst ovf", {31'd0, ovf}, 32'd0);
      rstn = 1'b1;
      run_op("3.0", 32'h4040_0000, 32'h0000_0003, 1'b0, 24);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
